// File: rtl/game_pkg.sv
// game_pkg: shared game-flow state encoding and widths
package game_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_MISS = 3'd2,
    ST_OVER = 3'd3,
    ST_WIN  = 3'd4
  } game_state_t;
  localparam int LIVES_W = 2;
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: registered single-cycle pulse on a 0->1 transition of d
module rise_edge_det (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic rise
);
  logic d_q;
  // remember last level and flag a rising transition one cycle later
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      d_q  <= 1'b0;
      rise <= 1'b0;
    end else begin
      d_q  <= d;
      rise <= d & ~d_q;
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: title/play/miss/over/win sequencer, lives counter and respawn pause
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int FREEZE_FRAMES = 90,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               hitBottomBoarder,
  input  logic               bricksCleared,
  output game_state_t        gameState,
  output logic [LIVES_W-1:0] lives,
  output logic               motionEnable,
  output logic               marioVisible,
  output logic               resultShow,
  output logic               resultWin,
  output logic               respawn
);
  localparam int FC_W = $clog2(FREEZE_FRAMES + 1);
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FREEZE_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);
  localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(LIVES_INIT);
  logic start_edge, miss_latch, miss_now;
  logic [FC_W-1:0] frame_cnt;
  logic [BC_W-1:0] blink_cnt;
  logic [LIVES_W-1:0] lives_dec;
  rise_edge_det u_start (
    .clk    (clk),
    .resetN (resetN),
    .d      (startKey),
    .rise   (start_edge)
  );
  assign miss_now  = miss_latch | hitBottomBoarder;
  assign lives_dec = (lives == '0) ? lives : lives - LIVES_W'(1);
  // collect bottom hits over one play frame so at most one life goes per frame
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) miss_latch <= 1'b0;
    else miss_latch <= (gameState == ST_PLAY) && !startOfFrame && miss_now;
  // game flow with registered outputs, lives and pause/blink counters
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      gameState    <= ST_IDLE;
      lives        <= L_INIT;
      motionEnable <= 1'b0;
      marioVisible <= 1'b1;
      resultShow   <= 1'b0;
      resultWin    <= 1'b0;
      respawn      <= 1'b0;
      frame_cnt    <= '0;
      blink_cnt    <= '0;
    end else begin
      respawn <= 1'b0;
      case (gameState)
        ST_IDLE:
          if (start_edge) begin
            lives        <= L_INIT;
            respawn      <= 1'b1;
            motionEnable <= 1'b1;
            gameState    <= ST_PLAY;
          end
        ST_PLAY:
          if (startOfFrame) begin
            if (bricksCleared) begin
              gameState    <= ST_WIN;
              motionEnable <= 1'b0;
              resultShow   <= 1'b1;
              resultWin    <= 1'b1;
            end else if (miss_now) begin
              lives        <= lives_dec;
              motionEnable <= 1'b0;
              if (lives_dec == '0) begin
                gameState  <= ST_OVER;
                resultShow <= 1'b1;
                resultWin  <= 1'b0;
              end else begin
                gameState    <= ST_MISS;
                marioVisible <= 1'b0;
                frame_cnt    <= '0;
                blink_cnt    <= '0;
              end
            end
          end
        ST_MISS:
          if (startOfFrame) begin
            if (frame_cnt == FC_LAST) begin
              gameState    <= ST_PLAY;
              respawn      <= 1'b1;
              motionEnable <= 1'b1;
              marioVisible <= 1'b1;
            end else begin
              frame_cnt    <= frame_cnt + FC_W'(1);
              blink_cnt    <= (blink_cnt == BC_LAST) ? '0 : blink_cnt + BC_W'(1);
              marioVisible <= (blink_cnt == BC_LAST) ? ~marioVisible : marioVisible;
            end
          end
        ST_OVER, ST_WIN:
          if (start_edge) begin
            gameState    <= ST_IDLE;
            resultShow   <= 1'b0;
            resultWin    <= 1'b0;
            marioVisible <= 1'b1;
          end
        default: gameState <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed test-plan scenarios plus random play against a behavioural model
module tb_game_flow_ctrl;
  import game_pkg::*;
  localparam int LI = 3, FF = 4, BF = 2;
  logic clk = 0, resetN = 0, startOfFrame = 0, startKey = 0, hitBottomBoarder = 0, bricksCleared = 0;
  game_state_t gameState;
  logic [LIVES_W-1:0] lives;
  logic motionEnable, marioVisible, resultShow, resultWin, respawn;
  int checks = 0, errors = 0;
  game_flow_ctrl #(.LIVES_INIT(LI), .FREEZE_FRAMES(FF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .hitBottomBoarder(hitBottomBoarder), .bricksCleared(bricksCleared),
    .gameState(gameState), .lives(lives), .motionEnable(motionEnable),
    .marioVisible(marioVisible), .resultShow(resultShow), .resultWin(resultWin),
    .respawn(respawn)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // model: 0 idle, 1 play, 2 miss, 3 over, 4 win; pause counts frames spent paused
  int m_state = 0, m_lives = LI, m_pause = 0;
  bit m_hit = 0, m_resp = 0, m_prev = 0, m_pend = 0;
  always @(posedge clk or negedge resetN) begin
    bit act;
    if (!resetN) begin
      m_state = 0; m_lives = LI; m_pause = 0;
      m_hit = 0; m_resp = 0; m_prev = 0; m_pend = 0;
    end else begin
      act = m_pend;
      m_pend = startKey && !m_prev;
      m_prev = startKey;
      m_resp = 0;
      if (m_state == 0) begin
        if (act) begin m_state = 1; m_lives = LI; m_resp = 1; m_hit = 0; end
      end else if (m_state == 1) begin
        if (hitBottomBoarder) m_hit = 1;
        if (startOfFrame) begin
          if (bricksCleared) m_state = 4;
          else if (m_hit) begin
            if (m_lives > 0) m_lives--;
            m_state = (m_lives == 0) ? 3 : 2;
            m_pause = 0;
          end
          m_hit = 0;
        end
      end else if (m_state == 2) begin
        if (startOfFrame) begin
          m_pause++;
          if (m_pause == FF) begin m_state = 1; m_resp = 1; m_hit = 0; end
        end
      end else if (act) m_state = 0;
    end
    #1;
    chk("gameState", int'(gameState), m_state);
    chk("lives", int'(lives), m_lives);
    chk("motionEnable", motionEnable, m_state == 1);
    chk("marioVisible", marioVisible, m_state == 2 ? (m_pause / BF) % 2 : 1);
    chk("resultShow", resultShow, m_state >= 3);
    chk("resultWin", resultWin, m_state == 4);
    chk("respawn", respawn, m_resp);
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press();
    startKey = 1; @(negedge clk); startKey = 0; @(negedge clk);
  endtask
  task automatic sof_pulse();
    startOfFrame = 1; @(negedge clk); startOfFrame = 0;
  endtask
  task automatic miss();
    hitBottomBoarder = 1; @(negedge clk); hitBottomBoarder = 0; idle(1); sof_pulse();
  endtask
  task automatic pause();
    repeat (FF) begin idle(2); sof_pulse(); end
    idle(1);
  endtask
  initial begin
    bit exp_vis [4] = '{0, 0, 1, 1};
    idle(3); resetN = 1; idle(1);
    chk("rst_state", int'(gameState), 0); chk("rst_lives", int'(lives), 3);
    chk("rst_vis", marioVisible, 1);
    // start
    press();
    chk("start_state", int'(gameState), 1); chk("start_lives", int'(lives), 3);
    chk("start_respawn", respawn, 1); chk("start_motion", motionEnable, 1);
    idle(1); chk("start_respawn_end", respawn, 0);
    // one miss per frame despite 200 hit cycles
    hitBottomBoarder = 1; idle(200); hitBottomBoarder = 0; sof_pulse();
    chk("miss1_lives", int'(lives), 2); chk("miss1_state", int'(gameState), 2);
    for (int i = 0; i < 4; i++) begin
      chk("blink", marioVisible, exp_vis[i]); idle(2); sof_pulse();
    end
    chk("resume_state", int'(gameState), 1); chk("resume_respawn", respawn, 1);
    chk("resume_vis", marioVisible, 1);
    idle(1); chk("resume_respawn_end", respawn, 0);
    // second miss, with start edge and hits ignored during pause
    miss();
    chk("miss2_lives", int'(lives), 1); chk("miss2_state", int'(gameState), 2);
    press(); hitBottomBoarder = 1; idle(5); hitBottomBoarder = 0; sof_pulse();
    chk("pause_ignore_state", int'(gameState), 2); chk("pause_ignore_lives", int'(lives), 1);
    repeat (3) begin idle(2); sof_pulse(); end
    chk("miss2_resume", int'(gameState), 1);
    // game over with key already held
    startKey = 1; idle(3); miss();
    chk("over_lives", int'(lives), 0); chk("over_state", int'(gameState), 3);
    chk("over_show", resultShow, 1); chk("over_win", resultWin, 0);
    idle(5); chk("over_held_key", int'(gameState), 3);
    startKey = 0; idle(2); press();
    chk("over_exit", int'(gameState), 0);
    // simultaneous miss and bricks cleared at one life
    press(); chk("g2_lives", int'(lives), 3);
    miss(); pause(); miss(); pause();
    chk("g2_lives1", int'(lives), 1); chk("g2_play", int'(gameState), 1);
    hitBottomBoarder = 1; bricksCleared = 1; @(negedge clk); hitBottomBoarder = 0;
    sof_pulse(); bricksCleared = 0;
    chk("win_state", int'(gameState), 4); chk("win_sel", resultWin, 1);
    chk("win_lives", int'(lives), 1); chk("win_show", resultShow, 1);
    press(); chk("win_exit", int'(gameState), 0);
    // asynchronous reset mid-pause
    press(); idle(2); miss(); chk("g3_miss", int'(gameState), 2);
    idle(2); sof_pulse(); idle(2); sof_pulse(); idle(1);
    #2 resetN = 0; #1;
    chk("arst_state", int'(gameState), 0); chk("arst_lives", int'(lives), 3);
    chk("arst_motion", motionEnable, 0); chk("arst_vis", marioVisible, 1);
    chk("arst_show", resultShow, 0); chk("arst_win", resultWin, 0); chk("arst_resp", respawn, 0);
    @(negedge clk); resetN = 1; idle(1); sof_pulse(); idle(1);
    chk("post_rst_state", int'(gameState), 0); chk("post_rst_lives", int'(lives), 3);
    // random play
    repeat (4000) begin
      startOfFrame = ($urandom_range(0, 5) == 0);
      hitBottomBoarder = ($urandom_range(0, 9) == 0);
      bricksCleared = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) startKey = ~startKey;
      resetN = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    resetN = 1; idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
